// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if -- bundle of every handshake/bus signal of the two-port line
// arbiter (dcache port 0, icache port 1) and its main-memory side.
//
// Parameters
//   ADDR_W  byte address width of all address signals
//   LINE_W  cache line width of all data signals
//
// Signals
//   p0_* / p1_*   client ports: req, w_en, addr, w_data in; ack, r_data, err out
//   mem_*         memory side: req, w_en, addr, w_data out; ack, r_data in
//
// Modports
//   slave   the arbiter's view (clients and memory answer to it)
//   master  the environment's view (clients plus memory model)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  // port 0 (dcache)
  logic              p0_req;
  logic              p0_w_en;
  logic [ADDR_W-1:0] p0_addr;
  logic [LINE_W-1:0] p0_w_data;
  logic              p0_ack;
  logic [LINE_W-1:0] p0_r_data;
  logic              p0_err;
  // port 1 (icache)
  logic              p1_req;
  logic              p1_w_en;
  logic [ADDR_W-1:0] p1_addr;
  logic [LINE_W-1:0] p1_w_data;
  logic              p1_ack;
  logic [LINE_W-1:0] p1_r_data;
  logic              p1_err;
  // main memory
  logic              mem_req;
  logic              mem_w_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_w_data;
  logic              mem_ack;
  logic [LINE_W-1:0] mem_r_data;

  modport slave (
    input  p0_req, p0_w_en, p0_addr, p0_w_data,
    output p0_ack, p0_r_data, p0_err,
    input  p1_req, p1_w_en, p1_addr, p1_w_data,
    output p1_ack, p1_r_data, p1_err,
    output mem_req, mem_w_en, mem_addr, mem_w_data,
    input  mem_ack, mem_r_data
  );

  modport master (
    output p0_req, p0_w_en, p0_addr, p0_w_data,
    input  p0_ack, p0_r_data, p0_err,
    output p1_req, p1_w_en, p1_addr, p1_w_data,
    input  p1_ack, p1_r_data, p1_err,
    input  mem_req, mem_w_en, mem_addr, mem_w_data,
    output mem_ack, mem_r_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter -- two-port round-robin arbiter in front of a single main-memory
// line port. One transaction is in flight at a time: IDLE grants, BUSY holds
// the registered request until memory acknowledges, RESP returns the captured
// line to the granted port for exactly one cycle.
//
// Parameters
//   ADDR_W       byte address width
//   LINE_W       cache line width
//   TIMEOUT_CYC  BUSY cycle limit (1..255), only acted on with the timeout build
//
// Ports
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mem_arbiter_if.slave: p0_*/p1_* client ports and mem_* memory port
//
// Build option
//   MEM_ARB_TIMEOUT_EN  when defined, an 8-bit BUSY watchdog completes a stuck
//                       transaction with err=1 and r_data=0. When undefined the
//                       arbiter waits forever for mem_ack and err is always 0.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 128,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // The watchdog counter is 8 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_timeout_range_check
    $error("mem_arbiter: TIMEOUT_CYC must be in 1..255");
  end

  // ---------------------------------------------------------------------------
  // Client ports gathered into index-able form (index = port number)
  // ---------------------------------------------------------------------------
  logic [1:0]        req_vec;
  logic [1:0]        w_en_vec;
  logic [ADDR_W-1:0] addr_arr   [2];
  logic [LINE_W-1:0] w_data_arr [2];

  assign req_vec       = {bus.p1_req, bus.p0_req};
  assign w_en_vec      = {bus.p1_w_en, bus.p0_w_en};
  assign addr_arr[0]   = bus.p0_addr;
  assign addr_arr[1]   = bus.p1_addr;
  assign w_data_arr[0] = bus.p0_w_data;
  assign w_data_arr[1] = bus.p1_w_data;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            state_reg,      state_next;
  logic              grant_reg,      grant_next;       // port owning the transaction
  logic              last_grant_reg, last_grant_next;  // port served most recently
  logic              mem_req_reg,    mem_req_next;
  logic              mem_w_en_reg,   mem_w_en_next;
  logic [ADDR_W-1:0] mem_addr_reg,   mem_addr_next;
  logic [LINE_W-1:0] mem_w_data_reg, mem_w_data_next;
  logic [LINE_W-1:0] r_data_reg,     r_data_next;      // line returned in RESP
  logic              sel;                              // IDLE grant choice

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = TIMEOUT_CYC[7:0];
  logic [7:0]        cnt_reg,        cnt_next;
  logic              err_reg,        err_next;
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      // Port 1 counts as served last so that port 0 wins the first tie.
      last_grant_reg <= 1'b1;
      mem_req_reg    <= 1'b0;
      mem_w_en_reg   <= 1'b0;
      mem_addr_reg   <= '0;
      mem_w_data_reg <= '0;
      r_data_reg     <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_reg        <= '0;
      err_reg        <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      mem_req_reg    <= mem_req_next;
      mem_w_en_reg   <= mem_w_en_next;
      mem_addr_reg   <= mem_addr_next;
      mem_w_data_reg <= mem_w_data_next;
      r_data_reg     <= r_data_next;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_reg        <= cnt_next;
      err_reg        <= err_next;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    mem_req_next    = mem_req_reg;
    mem_w_en_next   = mem_w_en_reg;
    mem_addr_next   = mem_addr_reg;
    mem_w_data_next = mem_w_data_reg;
    r_data_next     = r_data_reg;
    sel             = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_next        = cnt_reg;
    err_next        = err_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (req_vec != 2'b00) begin
          // On a tie take the port that was not served last; otherwise the
          // single requester.
          if (req_vec == 2'b11) begin
            sel = ~last_grant_reg;
          end else begin
            sel = req_vec[1];
          end
          grant_next      = sel;
          mem_req_next    = 1'b1;
          mem_w_en_next   = w_en_vec[sel];
          mem_addr_next   = addr_arr[sel];
          mem_w_data_next = w_data_arr[sel];
          state_next      = BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_next        = '0;
`endif
        end
      end

      BUSY: begin
        // mem_req is dropped on the same edge that leaves BUSY, so it is low
        // in the cycle after mem_ack.
        if (bus.mem_ack) begin
          r_data_next  = bus.mem_r_data;
          mem_req_next = 1'b0;
          state_next   = RESP;
`ifdef MEM_ARB_TIMEOUT_EN
          err_next     = 1'b0;
        end else if (cnt_reg == TIMEOUT_LIM) begin
          // A real ack in this same cycle was handled above and wins.
          r_data_next  = '0;
          err_next     = 1'b1;
          mem_req_next = 1'b0;
          state_next   = RESP;
        end else begin
          cnt_next     = cnt_reg + 8'd1;
`endif
        end
      end

      RESP: begin
        last_grant_next = grant_reg;
        state_next      = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: acks are decoded from the state register so only the granted
  // port can ever see one; r_data/err are forced to 0 outside its ack.
  // ---------------------------------------------------------------------------
  logic [1:0] ack_vec;

  assign ack_vec[0] = (state_reg == RESP) && !grant_reg;
  assign ack_vec[1] = (state_reg == RESP) &&  grant_reg;

  assign bus.p0_ack    = ack_vec[0];
  assign bus.p1_ack    = ack_vec[1];
  assign bus.p0_r_data = ack_vec[0] ? r_data_reg : '0;
  assign bus.p1_r_data = ack_vec[1] ? r_data_reg : '0;

`ifdef MEM_ARB_TIMEOUT_EN
  assign bus.p0_err = ack_vec[0] & err_reg;
  assign bus.p1_err = ack_vec[1] & err_reg;
`else
  assign bus.p0_err = 1'b0;
  assign bus.p1_err = 1'b0;
`endif

  assign bus.mem_req    = mem_req_reg;
  assign bus.mem_w_en   = mem_w_en_reg;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.mem_w_data = mem_w_data_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // memory model knobs
  int          mem_lat    = 1;
  bit          mem_never  = 0;
  bit          spur_en    = 0;
  bit          ovr_en     = 0;
  logic [LW-1:0] ovr_line = '0;
  int          mem_cnt    = 0;
  bit          mem_sent   = 0;

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    return {a ^ 32'h5A5A_0000, ~a, a + 32'h1111, a * 3};
  endfunction

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_dut();
    bus.p0_req = 0;
    bus.p1_req = 0;
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  // Memory: acks mem_lat cycles after mem_req rises, returns line_of(addr)
  // (or the override line); optionally sprays acks while mem_req is low.
  initial begin
    bus.mem_ack    = 0;
    bus.mem_r_data = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ack    = 0;
      bus.mem_r_data = {$urandom, $urandom, $urandom, $urandom};
      if (bus.mem_req) begin
        mem_cnt++;
        if (!mem_sent && !mem_never && mem_cnt == mem_lat + 1) begin
          bus.mem_ack    = 1;
          bus.mem_r_data = ovr_en ? ovr_line : line_of(bus.mem_addr);
          mem_sent       = 1;
        end
      end else begin
        mem_cnt  = 0;
        mem_sent = 0;
        if (spur_en && $urandom_range(0, 3) == 0) bus.mem_ack = 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Table of transaction vectors (run back to back after one reset)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          req0, req1;
    logic          we0, we1;
    logic [AW-1:0] a0, a1;
    logic [LW-1:0] d0, d1;
    int            first;   // port expected to be served first
    int            nexp;    // transactions expected (1 or 2)
  } vec_t;

  vec_t vecs [8];

  task automatic run_vec(input int vi, input vec_t v);
    int   idx = 0;
    int   order [2];
    int   port;
    logic prev_req = 0;
    order[0] = v.first;
    order[1] = 1 - v.first;
    bus.p0_req = v.req0; bus.p0_w_en = v.we0; bus.p0_addr = v.a0; bus.p0_w_data = v.d0;
    bus.p1_req = v.req1; bus.p1_w_en = v.we1; bus.p1_addr = v.a1; bus.p1_w_data = v.d1;
    for (int k = 0; k < 60 && idx < v.nexp; k++) begin
      step();
      check($sformatf("vec%0d_both_ack", vi), bus.p0_ack & bus.p1_ack, 0);
      if (bus.mem_req && !prev_req) begin
        port = order[idx];
        check($sformatf("vec%0d_mem_addr", vi), bus.mem_addr, port ? v.a1 : v.a0);
        check($sformatf("vec%0d_mem_w_en", vi), bus.mem_w_en, port ? v.we1 : v.we0);
        check($sformatf("vec%0d_mem_w_data", vi), bus.mem_w_data, port ? v.d1 : v.d0);
      end
      prev_req = bus.mem_req;
      if (bus.p0_ack || bus.p1_ack) begin
        port = bus.p1_ack ? 1 : 0;
        check($sformatf("vec%0d_order", vi), port, order[idx]);
        check($sformatf("vec%0d_r_data", vi), port ? bus.p1_r_data : bus.p0_r_data,
              line_of(port ? v.a1 : v.a0));
        check($sformatf("vec%0d_err", vi), bus.p0_err | bus.p1_err, 0);
        if (port == 1) bus.p1_req = 0; else bus.p0_req = 0;
        idx++;
      end
    end
    check($sformatf("vec%0d_done", vi), idx, v.nexp);
    bus.p0_req = 0;
    bus.p1_req = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model state for the randomized phase
  // ---------------------------------------------------------------------------
  bit            pend [2];
  bit            dropped [2];
  logic [AW-1:0] r_addr [2];
  logic          r_we [2];
  logic [LW-1:0] r_wd [2];

  initial begin
    int a0c, a1c, rise2, nacks, k0, rise, ackc, busy_n, ack_n;
    int seq [8];
    int cnt0, cnt1;
    // model
    int free_at, cur_port, cur_grant, cur_lat;
    bit last, cur_valid, e_req, e0, e1;
    logic [AW-1:0] cur_addr;
    logic          cur_we;
    logic [LW-1:0] cur_wd;

    bus.p0_req = 0; bus.p0_w_en = 0; bus.p0_addr = '0; bus.p0_w_data = '0;
    bus.p1_req = 0; bus.p1_w_en = 0; bus.p1_addr = '0; bus.p1_w_data = '0;

    // ---------------- reset values ----------------
    step();
    step();
    check("rst_mem_req",    bus.mem_req, 0);
    check("rst_mem_w_en",   bus.mem_w_en, 0);
    check("rst_mem_addr",   bus.mem_addr, 0);
    check("rst_mem_w_data", bus.mem_w_data, 0);
    check("rst_acks",       {bus.p1_ack, bus.p0_ack}, 0);
    check("rst_errs",       {bus.p1_err, bus.p0_err}, 0);
    check("rst_p0_r_data",  bus.p0_r_data, 0);
    check("rst_p1_r_data",  bus.p1_r_data, 0);
    rst_n = 1;

    // ---------------- single p0 read, 1-cycle memory ----------------
    mem_lat  = 1;
    ovr_en   = 1;
    ovr_line = {16{8'hA5}};
    bus.p0_req = 1; bus.p0_w_en = 0; bus.p0_addr = 32'h100;         // cycle 0
    step();                                                          // cycle 1
    check("rd_c1_mem_req", bus.mem_req, 1);
    check("rd_c1_mem_addr", bus.mem_addr, 32'h100);
    check("rd_c1_mem_w_en", bus.mem_w_en, 0);
    step();                                                          // cycle 2
    check("rd_c2_mem_req", bus.mem_req, 1);
    check("rd_c2_p0_ack", bus.p0_ack, 0);
    step();                                                          // cycle 3
    check("rd_c3_mem_req", bus.mem_req, 0);
    check("rd_c3_p0_ack", bus.p0_ack, 1);
    check("rd_c3_p0_r_data", bus.p0_r_data, {16{8'hA5}});
    check("rd_c3_p1_ack", bus.p1_ack, 0);
    bus.p0_req = 0;
    step();                                                          // cycle 4
    check("rd_c4_p0_ack", bus.p0_ack, 0);
    ovr_en = 0;

    // ---------------- simultaneous requests after reset ----------------
    reset_dut();
    bus.p0_req = 1; bus.p0_w_en = 0; bus.p0_addr = 32'h200;
    bus.p1_req = 1; bus.p1_w_en = 0; bus.p1_addr = 32'h300;
    a0c = -1; a1c = -1; rise2 = -1; nacks = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (bus.mem_req && bus.mem_addr == 32'h300 && rise2 < 0) rise2 = k;
      if (bus.p0_ack) begin a0c = k; bus.p0_req = 0; end
      if (bus.p1_ack) begin a1c = k; bus.p1_req = 0; end
    end
    check("tie_p0_ack_cycle", a0c, 3);
    check("tie_p1_mem_req_cycle", rise2, 5);
    check("tie_p1_ack_cycle", a1c, 7);

    // ---------------- continuous contention: 8 transactions ----------------
    reset_dut();
    bus.p0_req = 1; bus.p0_addr = 32'h1000;
    bus.p1_req = 1; bus.p1_addr = 32'h2000;
    nacks = 0;
    for (int k = 0; k < 100 && nacks < 8; k++) begin
      step();
      check("rr_both_ack", bus.p0_ack & bus.p1_ack, 0);
      if (bus.p0_ack || bus.p1_ack) begin
        seq[nacks] = bus.p1_ack ? 1 : 0;
        nacks++;
      end
    end
    bus.p0_req = 0;
    bus.p1_req = 0;
    check("rr_count", nacks, 8);
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < nacks; i++) begin
      check($sformatf("rr_grant%0d", i), seq[i], i % 2);
      if (seq[i] == 0) cnt0++; else cnt1++;
    end
    check("rr_p0_acks", cnt0, 4);
    check("rr_p1_acks", cnt1, 4);
    step();

    // ---------------- p1 write held stable through BUSY ----------------
    mem_lat = 3;
    bus.p1_req = 1; bus.p1_w_en = 1; bus.p1_addr = 32'h40; bus.p1_w_data = 128'h1234;
    busy_n = 0; ack_n = 0; cnt0 = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (bus.mem_req) begin
        busy_n++;
        check("wr_mem_w_en", bus.mem_w_en, 1);
        check("wr_mem_addr", bus.mem_addr, 32'h40);
        check("wr_mem_w_data", bus.mem_w_data, 128'h1234);
      end
      if (bus.p1_ack) begin
        ack_n++;
        check("wr_r_data", bus.p1_r_data, line_of(32'h40));
        bus.p1_req = 0;
      end
      if (bus.p0_ack) cnt0++;
    end
    check("wr_busy_cycles", busy_n, 4);
    check("wr_p1_ack_count", ack_n, 1);
    check("wr_p0_ack_count", cnt0, 0);
    bus.p1_w_en = 0;

    // ---------------- reset pulse in BUSY ----------------
    mem_lat = 5;
    bus.p0_req = 1; bus.p0_w_en = 1; bus.p0_addr = 32'h80; bus.p0_w_data = 128'hBEEF;
    step();
    step();
    check("rb_busy_mem_req", bus.mem_req, 1);
    rst_n = 0;
    #1;
    check("rb_mem_req", bus.mem_req, 0);
    check("rb_mem_w_en", bus.mem_w_en, 0);
    check("rb_mem_addr", bus.mem_addr, 0);
    check("rb_mem_w_data", bus.mem_w_data, 0);
    check("rb_acks", {bus.p1_ack, bus.p0_ack}, 0);
    bus.p0_req = 0;
    step();
    rst_n = 1;
    ack_n = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus.p0_ack || bus.p1_ack) ack_n++;
    end
    check("rb_no_ack", ack_n, 0);
    mem_lat = 1;
    bus.p0_req = 1; bus.p0_w_en = 0; bus.p0_addr = 32'h180;
    a0c = -1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (bus.p0_ack && a0c < 0) begin
        a0c = k;
        check("rb_new_r_data", bus.p0_r_data, line_of(32'h180));
        bus.p0_req = 0;
      end
    end
    check("rb_new_ack_cycle", a0c, 3);

    // ---------------- request dropped while granted ----------------
    mem_lat = 2;
    bus.p0_req = 1; bus.p0_addr = 32'h2C0;
    step();
    bus.p0_req = 0;
    ack_n = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.p0_ack) begin
        ack_n++;
        check("drop_r_data", bus.p0_r_data, line_of(32'h2C0));
      end
    end
    check("drop_ack_count", ack_n, 1);

`ifdef MEM_ARB_TIMEOUT_EN
    // ---------------- watchdog: no ack, then ack on the limit cycle ----------
    for (int t = 0; t < 2; t++) begin
      mem_never = (t == 0);
      mem_lat   = TO;
      bus.p0_req = 1; bus.p0_w_en = 0; bus.p0_addr = 32'h900;
      rise = -1; ackc = -1;
      for (int k = 1; k <= 20; k++) begin
        step();
        if (bus.mem_req && rise < 0) rise = k;
        if (bus.p0_ack && ackc < 0) begin
          ackc = k;
          check($sformatf("to%0d_err", t), bus.p0_err, (t == 0) ? 1 : 0);
          check($sformatf("to%0d_r_data", t), bus.p0_r_data, (t == 0) ? '0 : line_of(32'h900));
          check($sformatf("to%0d_mem_req", t), bus.mem_req, 0);
          bus.p0_req = 0;
        end
      end
      check($sformatf("to%0d_ack_delay", t), ackc - rise, 5);
    end
    mem_never = 0;
`endif

    // ---------------- table-driven vectors ----------------
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0,   128'h0,     128'h0,    0, 1};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,   32'h40,  128'h0,     128'h1234, 1, 1};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h500, 32'h600, 128'hDEAD,  128'h0,    0, 2};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h700, 32'h0,   128'h0,     128'h0,    0, 1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h810, 32'h820, 128'h0,     128'h77,   1, 2};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h830, 32'h840, 128'h11,    128'h22,   1, 2};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h850, 128'h0,     128'h0,    1, 1};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h860, 32'h870, 128'h0,     128'h0,    0, 2};
    mem_lat = 2;
    reset_dut();
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);
    step();

    // ---------------- randomized traffic vs reference model ----------------
    spur_en = 1;
    reset_dut();
    free_at = cyc; last = 1; cur_valid = 0;
    cur_port = 0; cur_grant = 0; cur_lat = 1;
    cur_addr = '0; cur_we = 0; cur_wd = '0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; dropped[p] = 0; r_addr[p] = '0; r_we[p] = 0; r_wd[p] = '0;
    end
    for (int n = 0; n < 500; n++) begin
      // expectations for this cycle
      e_req = cur_valid && cyc >= cur_grant + 1 && cyc <= cur_grant + 1 + cur_lat;
      e0    = cur_valid && cur_port == 0 && cyc == cur_grant + 2 + cur_lat;
      e1    = cur_valid && cur_port == 1 && cyc == cur_grant + 2 + cur_lat;
      check("rnd_mem_req", bus.mem_req, e_req);
      if (e_req) begin
        check("rnd_mem_addr", bus.mem_addr, cur_addr);
        check("rnd_mem_w_en", bus.mem_w_en, cur_we);
        check("rnd_mem_w_data", bus.mem_w_data, cur_wd);
      end
      check("rnd_p0_ack", bus.p0_ack, e0);
      check("rnd_p1_ack", bus.p1_ack, e1);
      check("rnd_p0_r_data", bus.p0_r_data, e0 ? line_of(cur_addr) : '0);
      check("rnd_p1_r_data", bus.p1_r_data, e1 ? line_of(cur_addr) : '0);
      check("rnd_errs", {bus.p1_err, bus.p0_err}, 0);
      // retire
      if (e0 || e1) begin
        pend[cur_port] = 0;
        last           = cur_port[0];
        cur_valid      = 0;
        free_at        = cyc + 1;
      end
      // clients issue new requests
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p]    = 1;
          dropped[p] = 0;
          r_addr[p]  = $urandom & 32'hFFFF_FFF0;
          r_we[p]    = 1'($urandom_range(0, 1));
          r_wd[p]    = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      // granted client may let go of req early
      if (cur_valid && cyc > cur_grant && $urandom_range(0, 3) == 0) dropped[cur_port] = 1;
      // arbitration
      if (!cur_valid && cyc >= free_at && (pend[0] || pend[1])) begin
        cur_port  = (pend[0] && pend[1]) ? (last ? 0 : 1) : (pend[1] ? 1 : 0);
        cur_valid = 1;
        cur_grant = cyc;
        cur_lat   = $urandom_range(1, 4);
        mem_lat   = cur_lat;
        cur_addr  = r_addr[cur_port];
        cur_we    = r_we[cur_port];
        cur_wd    = r_wd[cur_port];
      end
      bus.p0_req = pend[0] && !(cur_valid && cur_port == 0 && dropped[0]);
      bus.p1_req = pend[1] && !(cur_valid && cur_port == 1 && dropped[1]);
      bus.p0_addr = r_addr[0]; bus.p0_w_en = r_we[0]; bus.p0_w_data = r_wd[0];
      bus.p1_addr = r_addr[1]; bus.p1_w_en = r_we[1]; bus.p1_w_data = r_wd[1];
      step();
    end
    spur_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte address width of all address ports.
REQ-002 Parameter LINE_W, default 128, cache line width of all data ports.
REQ-003 Parameter TIMEOUT_CYC, default 255, maximum BUSY cycles before a timeout (used only under REQ-031).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 p0_req / p1_req  in  1  line request from port 0 (dcache) / port 1 (icache); each held high until its ack.
REQ-007 p0_w_en / p1_w_en  in  1  1 = line write, 0 = line read.
REQ-008 p0_addr / p1_addr  in  ADDR_W  line address.
REQ-009 p0_w_data / p1_w_data  in  LINE_W  write line.
REQ-010 p0_ack / p1_ack  out  1  one-cycle completion pulse.
REQ-011 p0_r_data / p1_r_data  out  LINE_W  read line, valid while the matching ack is high.
REQ-012 p0_err / p1_err  out  1  timeout flag, valid while the matching ack is high.
REQ-013 mem_req, mem_w_en  out  1  request and write enable to main memory.
REQ-014 mem_addr  out  ADDR_W; mem_w_data  out  LINE_W  registered copies of the granted request.
REQ-015 mem_ack  in  1; mem_r_data  in  LINE_W  memory response; ack is a one-cycle pulse, earliest one cycle after mem_req rises.

Function
REQ-016 FSM states are IDLE, BUSY and RESP; only IDLE may grant.
REQ-017 IDLE, one port requesting: grant it, latch its addr, w_data and w_en into the mem_* registers, and go to BUSY.
REQ-018 IDLE, both ports requesting: grant the port not granted last (round robin); after reset, port 0 wins the first tie.
REQ-019 IDLE, no request: stay in IDLE with mem_req=0.
REQ-020 BUSY: mem_req=1 and the mem_* registers stay stable.
REQ-021 BUSY with mem_ack=1: capture mem_r_data, go to RESP, and clear mem_req at that same edge, so mem_req=0 in the cycle after mem_ack.
REQ-022 RESP (exactly one cycle): drive ack=1 and the captured r_data to the granted port only, update last-grant, and return to IDLE.
REQ-023 The other port's ack is 0 in every cycle; both acks are never high together.
REQ-024 Latency: request seen in IDLE at cycle 0 -> mem_req=1 at cycle 1 -> port ack at cycle (mem_ack cycle + 1); with a 1-cycle memory, ack is at cycle 3 and the next grant is possible at cycle 4.
REQ-025 A port that drops req while granted does not abort its transaction; its ack is still issued.
REQ-026 A request that arrives while BUSY or RESP waits in IDLE with no loss.
REQ-027 mem_ack seen in IDLE or RESP is ignored.
REQ-028 For a write, r_data is the memory's returned line, passed through unchanged.

Reset
REQ-029 While rst_n=0 (asynchronously): state=IDLE; mem_req, mem_w_en, mem_addr and mem_w_data are 0; both acks, errs and r_data are 0; last-grant=port 1; timeout counter=0.
REQ-030 Reset asserted in BUSY abandons the transaction, issues no ack, and the first cycle after release is IDLE.

Configuration
REQ-031 With MEM_ARB_TIMEOUT_EN defined: an 8-bit counter clears on entry to BUSY and increments each BUSY cycle; when it reaches TIMEOUT_CYC with no mem_ack, go to RESP with err=1, r_data=0 and mem_req cleared.
REQ-032 With MEM_ARB_TIMEOUT_EN defined: a mem_ack in the same cycle the timeout is reached takes priority, giving err=0 and real data.
REQ-033 Without MEM_ARB_TIMEOUT_EN: no counter exists, BUSY waits indefinitely for mem_ack, and p0_err/p1_err are tied to 0.

Verification
REQ-034 p0 read at addr 0x100 alone, memory acks 1 cycle later with 0xA5..A5 -> mem_req high for 2 cycles, p0_ack at cycle 3 with r_data 0xA5..A5, p1_ack stays 0.
REQ-035 p0 and p1 requests both rise at cycle 0 after reset -> p0 served first, p1 granted at cycle 4, p1_ack at cycle 7.
REQ-036 Both ports request continuously for 8 transactions -> grants strictly alternate p0,p1,p0,...; exactly 4 acks per port.
REQ-037 p1 write to 0x40 with data 0x1234 -> mem_w_en=1, mem_addr=0x40 and mem_w_data=0x1234 stable through BUSY; p1_ack asserted once.
REQ-038 rst_n pulsed low for 1 cycle during BUSY -> all outputs 0 at once, no ack issued, a new p0 request is then served normally.
REQ-039 MEM_ARB_TIMEOUT_EN with TIMEOUT_CYC=4 and mem_ack never asserted -> p0_ack with p0_err=1 and r_data=0, 5 cycles after mem_req rises.
